multisim_push_serializer: RTL and testbench



---
 rtl/multisim_push_serializer_pkg.sv | 18 +
 rtl/multisim_push_serializer_if.sv | 28 ++
 rtl/multisim_push_serializer_fifo.sv | 60 ++++++
 rtl/multisim_push_serializer.sv | 122 ++++++++++++
 tb/tb_multisim_push_serializer.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multisim_push_serializer_pkg.sv
// Shared types and elaboration helpers for the multisim push serializer.
// Beat count is the ceiling of payload width over beat width.
package multisim_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    function automatic int beats_for(input int in_w, input int out_w);
        return (in_w + out_w - 1) / out_w;
    endfunction

    function automatic bit cfg_ok(input int in_w, input int out_w, input int depth);
        return (in_w >= 1) && (out_w >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/multisim_push_serializer_if.sv
// Word-in / beat-out stream bundle; slave is the serializer, master is its feeder and sink.
interface multisim_push_serializer_if #(
    parameter int IN_WIDTH   = 256,
    parameter int OUT_WIDTH  = 64,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic                 in_vld;
    logic                 in_rdy;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 out_vld;
    logic                 out_rdy;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic [LVL_W-1:0]     fifo_level;

    modport master (
        output in_vld, in_data, out_rdy,
        input  in_rdy, out_vld, out_data, out_last, fifo_level
    );

    modport slave (
        input  in_vld, in_data, out_rdy,
        output in_rdy, out_vld, out_data, out_last, fifo_level
    );

endinterface

// File: rtl/multisim_push_serializer_fifo.sv
// Synchronous FIFO with registered storage, wrap-bit pointers and a registered level.
// Read data is the head entry, valid whenever empty is low; caller never pushes when full.
module multisim_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/multisim_push_serializer.sv
// Buffers wide words in a FIFO and emits each as BEATS LSB-first beats; first beat one cycle after accept.
// in_rdy drops only when the FIFO is full; output beats hold under out_rdy stall, no bubble between words.
module multisim_push_serializer
    import multisim_pkg::*;
#(
    parameter int IN_WIDTH   = 256,
    parameter int OUT_WIDTH  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    multisim_push_serializer_if.slave  bus
);
    localparam int BEATS = beats_for(IN_WIDTH, OUT_WIDTH);
    localparam int SHW   = BEATS * OUT_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = $clog2(FIFO_DEPTH + 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(BEATS - 1);

    if (!cfg_ok(IN_WIDTH, OUT_WIDTH, FIFO_DEPTH)) begin : g_cfg_err
        $error("multisim_push_serializer: illegal IN_WIDTH/OUT_WIDTH/FIFO_DEPTH");
    end

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [IN_WIDTH-1:0] fifo_dout;
    logic [LW-1:0]       fifo_level;

    ser_state_e     state_q, state_d;
    logic [BW-1:0]  beat_idx_q, beat_idx_d;
    logic [SHW-1:0] shift_q, shift_d;
    logic           out_vld_q, out_vld_d;
    logic           out_last_q, out_last_d;
    logic           last_beat;
    logic           xfer;

    assign bus.in_rdy     = !rst && !fifo_full;
    assign fifo_push      = bus.in_vld && bus.in_rdy;
    assign bus.fifo_level = fifo_level;

    multisim_sync_fifo #(
        .WIDTH (IN_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (bus.in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign last_beat = (beat_idx_q == LAST_IDX);
    assign xfer      = out_vld_q && bus.out_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_idx_q <= '0;
            shift_q    <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_idx_q <= beat_idx_d;
            shift_q    <= shift_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
        end
    end

    // Loading zero-extends the word, which pads the upper part of the final beat.
    always_comb begin
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = SHW'(fifo_dout);
                    beat_idx_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (!last_beat) begin
                        shift_d    = shift_q >> OUT_WIDTH;
                        beat_idx_d = beat_idx_q + BW'(1);
                    end else if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_d    = SHW'(fifo_dout);
                        beat_idx_d = '0;
                    end else begin
                        shift_d    = '0;
                        beat_idx_d = '0;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they come straight from flops.
    always_comb begin
        out_vld_d  = (state_d == SEND);
        out_last_d = (state_d == SEND) && (beat_idx_d == LAST_IDX);
    end

    assign bus.out_vld  = out_vld_q;
    assign bus.out_last = out_last_q;
    assign bus.out_data = shift_q[OUT_WIDTH-1:0];

endmodule

// File: tb/tb_multisim_push_serializer.sv
// Scoreboard bench for the push serializer: default 256/64/4 instance plus a 100-bit padding instance.
module tb_multisim_push_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multisim_push_serializer_if #(.IN_WIDTH(256), .OUT_WIDTH(64), .FIFO_DEPTH(4)) bus ();
    multisim_push_serializer_if #(.IN_WIDTH(100), .OUT_WIDTH(64), .FIFO_DEPTH(4)) pbus ();

    multisim_push_serializer #(.IN_WIDTH(256), .OUT_WIDTH(64), .FIFO_DEPTH(4)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
    );
    multisim_push_serializer #(.IN_WIDTH(100), .OUT_WIDTH(64), .FIFO_DEPTH(4)) dut_pad (
        .clk (clk), .rst (rst), .bus (pbus.slave)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } beat_t;

    beat_t exp_q [$];
    int    vec_cnt = 0;
    int    err_cnt = 0;

    task automatic step();
        @(negedge clk);
    endtask

    function automatic void exp_word(input logic [255:0] w);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(beat_t'({w[i*64 +: 64], (i == 3)}));
        end
    endfunction

    function automatic logic [255:0] rnd_word();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        vec_cnt++; if (bus.out_vld !== 1'b0) begin err_cnt++; $display("FAIL rst_out_vld: got %b expected 0", bus.out_vld); end
        vec_cnt++; if (bus.out_last !== 1'b0) begin err_cnt++; $display("FAIL rst_out_last: got %b expected 0", bus.out_last); end
        vec_cnt++; if (bus.out_data !== 64'h0) begin err_cnt++; $display("FAIL rst_out_data: got %h expected 0", bus.out_data); end
        vec_cnt++; if (bus.fifo_level !== 3'd0) begin err_cnt++; $display("FAIL rst_level: got %0d expected 0", bus.fifo_level); end
        vec_cnt++; if (bus.in_rdy !== 1'b0) begin err_cnt++; $display("FAIL rst_in_rdy: got %b expected 0", bus.in_rdy); end
        rst = 1'b0;
        #1;
        vec_cnt++; if (bus.in_rdy !== 1'b1) begin err_cnt++; $display("FAIL post_rst_in_rdy: got %b expected 1", bus.in_rdy); end
        step();
    endtask

    task automatic test_single();
        bus.in_data = {64'h4, 64'h3, 64'h2, 64'h1};
        bus.in_vld  = 1'b1;
        bus.out_rdy = 1'b1;
        step();
        bus.in_vld = 1'b0;
        vec_cnt++; if (bus.out_vld !== 1'b0) begin err_cnt++; $display("FAIL single_early_vld: got %b expected 0", bus.out_vld); end
        step();
        for (int i = 0; i < 4; i++) begin
            vec_cnt++;
            if (bus.out_vld !== 1'b1 || bus.out_data !== 64'(i + 1) || bus.out_last !== (i == 3)) begin
                err_cnt++;
                $display("FAIL single_beat%0d: got vld=%b data=%h last=%b expected vld=1 data=%h last=%b",
                         i, bus.out_vld, bus.out_data, bus.out_last, 64'(i + 1), (i == 3));
            end
            step();
        end
        vec_cnt++; if (bus.out_vld !== 1'b0) begin err_cnt++; $display("FAIL single_tail_vld: got %b expected 0", bus.out_vld); end
    endtask

    task automatic test_padding();
        pbus.out_rdy = 1'b1;
        pbus.in_data = '1;
        pbus.in_vld  = 1'b1;
        step();
        pbus.in_vld = 1'b0;
        step();
        vec_cnt++;
        if (pbus.out_vld !== 1'b1 || pbus.out_data !== 64'hFFFF_FFFF_FFFF_FFFF || pbus.out_last !== 1'b0) begin
            err_cnt++;
            $display("FAIL pad_beat0: got vld=%b data=%h last=%b expected vld=1 data=ffffffffffffffff last=0",
                     pbus.out_vld, pbus.out_data, pbus.out_last);
        end
        step();
        vec_cnt++;
        if (pbus.out_vld !== 1'b1 || pbus.out_data !== 64'h0000_000F_FFFF_FFFF || pbus.out_last !== 1'b1) begin
            err_cnt++;
            $display("FAIL pad_beat1: got vld=%b data=%h last=%b expected vld=1 data=0000000fffffffff last=1",
                     pbus.out_vld, pbus.out_data, pbus.out_last);
        end
        step();
        vec_cnt++; if (pbus.out_vld !== 1'b0) begin err_cnt++; $display("FAIL pad_tail_vld: got %b expected 0", pbus.out_vld); end
    endtask

    task automatic test_full_stall();
        logic [255:0] w [6];
        beat_t b;
        int acc = 0;
        int n = 0;
        bit chk_done = 0;
        for (int k = 0; k < 6; k++)
            for (int i = 0; i < 4; i++) w[k][i*64 +: 64] = {8'(k), 8'(i), 48'h5A5A_1234_0000};
        bus.out_rdy = 1'b0;
        bus.in_vld  = 1'b1;
        bus.in_data = w[0];
        for (int c = 0; c < 12; c++) begin
            if (bus.in_vld && bus.in_rdy) begin exp_word(w[acc]); acc++; end
            step();
            if (acc < 6) bus.in_data = w[acc]; else bus.in_vld = 1'b0;
        end
        bus.in_vld = 1'b0;
        vec_cnt++; if (acc != 5) begin err_cnt++; $display("FAIL stall_accepted: got %0d expected 5", acc); end
        vec_cnt++; if (bus.fifo_level !== 3'd4) begin err_cnt++; $display("FAIL stall_level: got %0d expected 4", bus.fifo_level); end
        vec_cnt++; if (bus.in_rdy !== 1'b0) begin err_cnt++; $display("FAIL stall_in_rdy: got %b expected 0", bus.in_rdy); end
        vec_cnt++;
        if (bus.out_vld !== 1'b1 || bus.out_data !== w[0][63:0]) begin
            err_cnt++;
            $display("FAIL stall_hold: got vld=%b data=%h expected vld=1 data=%h", bus.out_vld, bus.out_data, w[0][63:0]);
        end
        bus.out_rdy = 1'b1;
        for (int c = 0; c < 40 && n < 20; c++) begin
            if (n == 3) begin
                vec_cnt++; if (bus.in_rdy !== 1'b0) begin err_cnt++; $display("FAIL stall_rdy_early: got %b expected 0", bus.in_rdy); end
            end
            if (n == 4 && !chk_done) begin
                chk_done = 1;
                vec_cnt++;
                if (bus.in_rdy !== 1'b1 || bus.fifo_level !== 3'd3) begin
                    err_cnt++;
                    $display("FAIL stall_rdy_back: got rdy=%b level=%0d expected rdy=1 level=3", bus.in_rdy, bus.fifo_level);
                end
            end
            if (bus.out_vld) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++; $display("FAIL stall_beat: got unexpected beat %h expected none", bus.out_data);
                end else begin
                    b = exp_q.pop_front();
                    if (bus.out_data !== b.d || bus.out_last !== b.l) begin
                        err_cnt++;
                        $display("FAIL stall_beat%0d: got %h/%b expected %h/%b", n, bus.out_data, bus.out_last, b.d, b.l);
                    end
                end
                n++;
            end
            step();
        end
        vec_cnt++;
        if (n != 20 || exp_q.size() != 0 || bus.out_vld !== 1'b0) begin
            err_cnt++;
            $display("FAIL stall_drain: got beats=%0d left=%0d vld=%b expected beats=20 left=0 vld=0", n, exp_q.size(), bus.out_vld);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] w [8];
        beat_t b;
        int acc = 0;
        int n = 0;
        bit started = 0;
        for (int k = 0; k < 8; k++) w[k] = rnd_word();
        bus.out_rdy = 1'b1;
        bus.in_vld  = 1'b1;
        bus.in_data = w[0];
        for (int c = 0; c < 100 && n < 32; c++) begin
            if (bus.out_vld) begin
                started = 1;
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++; $display("FAIL b2b_beat: got unexpected beat %h expected none", bus.out_data);
                end else begin
                    b = exp_q.pop_front();
                    if (bus.out_data !== b.d || bus.out_last !== b.l || b.l !== (n % 4 == 3)) begin
                        err_cnt++;
                        $display("FAIL b2b_beat%0d: got %h/%b expected %h/%b", n, bus.out_data, bus.out_last, b.d, b.l);
                    end
                end
                n++;
            end else if (started) begin
                vec_cnt++; err_cnt++;
                $display("FAIL b2b_gap: got out_vld=0 after %0d beats expected 1", n);
            end
            if (bus.in_vld && bus.in_rdy) begin exp_word(w[acc]); acc++; end
            step();
            if (acc < 8) bus.in_data = w[acc]; else bus.in_vld = 1'b0;
        end
        bus.in_vld = 1'b0;
        step();
        vec_cnt++;
        if (n != 32 || exp_q.size() != 0 || bus.out_vld !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_count: got beats=%0d left=%0d vld=%b expected 32/0/0", n, exp_q.size(), bus.out_vld);
        end
    endtask

    task automatic test_random_bp();
        logic [255:0] w [6];
        logic [63:0]  prev_data = '0;
        logic         prev_last = 1'b0;
        logic         prev_vld = 1'b0;
        logic         prev_rdy = 1'b0;
        beat_t b;
        int acc = 0;
        int n = 0;
        for (int k = 0; k < 6; k++) w[k] = rnd_word();
        bus.in_vld  = 1'b1;
        bus.in_data = w[0];
        for (int c = 0; c < 300 && n < 24; c++) begin
            if (prev_vld && !prev_rdy) begin
                vec_cnt++;
                if (bus.out_vld !== 1'b1 || bus.out_data !== prev_data || bus.out_last !== prev_last) begin
                    err_cnt++;
                    $display("FAIL bp_hold: got vld=%b data=%h last=%b expected vld=1 data=%h last=%b",
                             bus.out_vld, bus.out_data, bus.out_last, prev_data, prev_last);
                end
            end
            bus.out_rdy = c[0];
            if (bus.out_vld && bus.out_rdy) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++; $display("FAIL bp_beat: got unexpected beat %h expected none", bus.out_data);
                end else begin
                    b = exp_q.pop_front();
                    if (bus.out_data !== b.d || bus.out_last !== b.l) begin
                        err_cnt++;
                        $display("FAIL bp_beat%0d: got %h/%b expected %h/%b", n, bus.out_data, bus.out_last, b.d, b.l);
                    end
                end
                n++;
            end
            if (bus.in_vld && bus.in_rdy) begin exp_word(w[acc]); acc++; end
            prev_vld  = bus.out_vld;
            prev_rdy  = bus.out_rdy;
            prev_data = bus.out_data;
            prev_last = bus.out_last;
            step();
            bus.in_vld = (acc < 6) && ($urandom_range(0, 1) == 1);
            if (acc < 6) bus.in_data = w[acc];
        end
        bus.in_vld  = 1'b0;
        bus.out_rdy = 1'b1;
        step();
        vec_cnt++;
        if (n != 24 || exp_q.size() != 0) begin
            err_cnt++; $display("FAIL bp_count: got beats=%0d left=%0d expected 24/0", n, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [255:0] w [4];
        logic [255:0] wn;
        beat_t b;
        int acc = 0;
        int n = 0;
        for (int k = 0; k < 4; k++) w[k] = rnd_word();
        wn = rnd_word();
        bus.out_rdy = 1'b0;
        bus.in_vld  = 1'b1;
        bus.in_data = w[0];
        for (int c = 0; c < 10 && acc < 4; c++) begin
            if (bus.in_rdy) acc++;
            step();
            if (acc < 4) bus.in_data = w[acc]; else bus.in_vld = 1'b0;
        end
        bus.in_vld = 1'b0;
        vec_cnt++; if (bus.fifo_level !== 3'd3) begin err_cnt++; $display("FAIL mr_level_pre: got %0d expected 3", bus.fifo_level); end
        bus.out_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vec_cnt++;
            if (bus.out_vld !== 1'b1 || bus.out_data !== w[0][i*64 +: 64]) begin
                err_cnt++;
                $display("FAIL mr_beat%0d: got vld=%b data=%h expected vld=1 data=%h", i, bus.out_vld, bus.out_data, w[0][i*64 +: 64]);
            end
            step();
        end
        bus.out_rdy = 1'b0;
        rst = 1'b1;
        #1;
        vec_cnt++;
        if (bus.out_vld !== 1'b0 || bus.fifo_level !== 3'd0 || bus.in_rdy !== 1'b0 || bus.out_data !== 64'h0) begin
            err_cnt++;
            $display("FAIL mr_async: got vld=%b level=%0d rdy=%b data=%h expected 0/0/0/0",
                     bus.out_vld, bus.fifo_level, bus.in_rdy, bus.out_data);
        end
        step();
        rst = 1'b0;
        step();
        vec_cnt++;
        if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b1) begin
            err_cnt++; $display("FAIL mr_release: got vld=%b rdy=%b expected vld=0 rdy=1", bus.out_vld, bus.in_rdy);
        end
        exp_word(wn);
        bus.in_data = wn;
        bus.in_vld  = 1'b1;
        bus.out_rdy = 1'b1;
        step();
        bus.in_vld = 1'b0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            if (bus.out_vld) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++; $display("FAIL mr_new_beat: got unexpected beat %h expected none", bus.out_data);
                end else begin
                    b = exp_q.pop_front();
                    if (bus.out_data !== b.d || bus.out_last !== b.l) begin
                        err_cnt++;
                        $display("FAIL mr_new_beat%0d: got %h/%b expected %h/%b", n, bus.out_data, bus.out_last, b.d, b.l);
                    end
                end
                n++;
            end
            step();
        end
        vec_cnt++;
        if (n != 4 || bus.out_vld !== 1'b0 || bus.fifo_level !== 3'd0) begin
            err_cnt++;
            $display("FAIL mr_new_done: got beats=%0d vld=%b level=%0d expected 4/0/0", n, bus.out_vld, bus.fifo_level);
        end
    endtask

    initial begin
        bus.in_vld   = 1'b0;
        bus.in_data  = '0;
        bus.out_rdy  = 1'b0;
        pbus.in_vld  = 1'b0;
        pbus.in_data = '0;
        pbus.out_rdy = 1'b0;
        test_reset();
        test_single();
        test_padding();
        test_full_stall();
        test_back_to_back();
        test_random_bp();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
